// File: rtl/fifo_ddr3_write_w32r256_if.sv
// Bus bundle for the 32-to-256 DDR3 write-path FIFO.
// The master side is the producer/consumer; the slave side is the FIFO.
`timescale 1ns/1ps
interface fifo_ddr3_write_w32r256_if #(
   parameter int unsigned WR_DATA_WIDTH = 32,
   parameter int unsigned RD_DATA_WIDTH = 256
);
   logic [WR_DATA_WIDTH-1:0] wr_data;
   logic                     wr_en;
   logic                     wr_full;
   logic                     almost_full;
   logic [RD_DATA_WIDTH-1:0] rd_data;
   logic                     rd_en;
   logic                     rd_empty;
   logic                     almost_empty;

   modport master (
      output wr_data, wr_en, rd_en,
      input  wr_full, almost_full, rd_data, rd_empty, almost_empty
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output wr_full, almost_full, rd_data, rd_empty, almost_empty
   );
endinterface

// File: rtl/fifo_ddr3_write_w32r256.sv
// Single-clock 32-bit-in / 256-bit-out FIFO for the DDR3 write path (512 x 32 storage).
// Optional macro FIFO_OUTPUT_REG_EN adds an output register after the RAM read (2-cycle read latency).
`timescale 1ns/1ps
module fifo_ddr3_write_w32r256 #(
   parameter int unsigned WR_DATA_WIDTH    = 32,
   parameter int unsigned WR_DEPTH_WIDTH   = 9,
   parameter int unsigned RD_DATA_WIDTH    = 256,
   parameter int unsigned RD_DEPTH_WIDTH   = 6,
   parameter int unsigned ALMOST_FULL_NUM  = 128,
   parameter int unsigned ALMOST_EMPTY_NUM = 15
) (
   input logic                   clk,
   input logic                   tb_rst,
   fifo_ddr3_write_w32r256_if.slave bus
);
   localparam int unsigned WR_DEPTH = 1 << WR_DEPTH_WIDTH;
   localparam int unsigned PACK     = RD_DATA_WIDTH / WR_DATA_WIDTH;
   localparam int unsigned PACK_W   = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
   localparam int unsigned CNT_W    = WR_DEPTH_WIDTH + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WR_DEPTH);
   localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_NUM);
   localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(ALMOST_EMPTY_NUM);

   logic [1:0]                rst_sync;
   logic                      rst;
   logic [WR_DEPTH_WIDTH:0]   wptr;
   logic [RD_DEPTH_WIDTH:0]   rptr;
   logic [CNT_W-1:0]          wcnt;
   logic [CNT_W-1:0]          wcnt_next_c;
   logic                      wr_ok_c;
   logic                      rd_ok_c;
   logic [RD_DATA_WIDTH-1:0]  rd_word_c;
   logic [RD_DATA_WIDTH-1:0]  rd_q;
   logic                      full_q;
   logic                      afull_q;
   logic                      empty_q;
   logic                      aempty_q;
   logic [WR_DATA_WIDTH-1:0]  mem [WR_DEPTH];

   // Reset asserts asynchronously and releases on the second clk edge after tb_rst falls.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) rst_sync <= 2'b11;
      else        rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst = rst_sync[1];

   // Acceptance uses the registered (pre-edge) flags.
   assign wr_ok_c = bus.wr_en & ~full_q;
   assign rd_ok_c = bus.rd_en & ~empty_q;

   always_comb begin
      wcnt_next_c = wcnt;
      if (wr_ok_c) wcnt_next_c = wcnt_next_c + CNT_W'(1);
      if (rd_ok_c) wcnt_next_c = wcnt_next_c - PACK_CNT;
   end

   // Oldest word of the read slot lands in the lowest lane.
   always_comb begin
      rd_word_c = '0;
      for (int unsigned k = 0; k < PACK; k++) begin
         rd_word_c[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] =
            mem[{rptr[RD_DEPTH_WIDTH-1:0], PACK_W'(k)}];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok_c) mem[wptr[WR_DEPTH_WIDTH-1:0]] <= bus.wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         wcnt     <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
      end else begin
         if (wr_ok_c) wptr <= wptr + (WR_DEPTH_WIDTH+1)'(1);
         if (rd_ok_c) rptr <= rptr + (RD_DEPTH_WIDTH+1)'(1);
         wcnt     <= wcnt_next_c;
         full_q   <= (wcnt_next_c == FULL_CNT);
         afull_q  <= (wcnt_next_c >= AF_CNT);
         empty_q  <= (wcnt_next_c < PACK_CNT);
         aempty_q <= ((wcnt_next_c >> PACK_W) <= AE_LVL);
      end
   end

`ifdef FIFO_OUTPUT_REG_EN
   logic [RD_DATA_WIDTH-1:0] ram_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_q <= '0;
         rd_q  <= '0;
      end else begin
         if (rd_ok_c) ram_q <= rd_word_c;
         rd_q <= ram_q;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_q <= '0;
      else if (rd_ok_c) rd_q <= rd_word_c;
   end
`endif

   assign bus.wr_full      = full_q;
   assign bus.almost_full  = afull_q;
   assign bus.rd_empty     = empty_q;
   assign bus.almost_empty = aempty_q;
   assign bus.rd_data      = rd_q;
endmodule

// File: tb/tb_fifo_ddr3_write_w32r256.sv
// Randomized self-checking bench for fifo_ddr3_write_w32r256 against a queue-based model.
// Honours FIFO_OUTPUT_REG_EN for the expected read latency.
`timescale 1ns/1ps
module tb_fifo_ddr3_write_w32r256;
   logic clk = 1'b0;
   logic tb_rst = 1'b1;
   bit   run_cmp = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fifo_ddr3_write_w32r256_if bus ();

   fifo_ddr3_write_w32r256 dut (
      .clk    (clk),
      .tb_rst (tb_rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model: a word queue; reads pop 8 words, oldest into lane 0.
   logic [31:0]  q [$];
   logic [255:0] m_rd = '0;
   logic [255:0] m_stage = '0;

   always @(posedge clk or posedge tb_rst) begin
      int n;
      bit wr_ok, rd_ok;
      logic [255:0] w;
      if (tb_rst) begin
         q.delete();
         m_rd    <= '0;
         m_stage <= '0;
      end else begin
         n     = q.size();
         wr_ok = bus.wr_en && (n != 512);
         rd_ok = bus.rd_en && (n >= 8);
         w     = '0;
         if (rd_ok)
            for (int k = 0; k < 8; k++) w[32*k +: 32] = q.pop_front();
         if (wr_ok) q.push_back(bus.wr_data);
`ifdef FIFO_OUTPUT_REG_EN
         if (rd_ok) m_stage <= w;
         m_rd <= m_stage;
`else
         if (rd_ok) m_rd <= w;
`endif
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int n;
      if (run_cmp) begin
         n = q.size();
         chk("wr_full",      256'(bus.wr_full),      256'(n == 512));
         chk("almost_full",  256'(bus.almost_full),  256'(n >= 128));
         chk("rd_empty",     256'(bus.rd_empty),     256'(n < 8));
         chk("almost_empty", 256'(bus.almost_empty), 256'((n >> 3) <= 15));
         chk("rd_data",      bus.rd_data,            m_rd);
      end
   end

   task automatic step(input logic we, input logic [31:0] wd, input logic re);
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 tb_rst = 1'b0;
      repeat (4) step(1'b0, 32'h0, 1'b0);
   endtask

   task automatic fill_drain_random();
      for (int i = 0; i < 600 && q.size() < 512; i++) step(1'b1, $urandom, 1'b0);
      for (int i = 0; i < 70 && q.size() >= 8; i++) step(1'b0, 32'h0, 1'b1);
      repeat (2) step(1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      logic [255:0] lit;
      int wp [4] = '{90, 50, 95, 30};
      int rp [4] = '{5, 30, 12, 40};
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_data = '0;
      #12 run_cmp = 1'b1;
      #200;
      chk("reset_rd_empty",     256'(bus.rd_empty),     256'(1));
      chk("reset_almost_empty", 256'(bus.almost_empty), 256'(1));
      chk("reset_wr_full",      256'(bus.wr_full),      256'(0));
      chk("reset_almost_full",  256'(bus.almost_full),  256'(0));
      chk("reset_rd_data",      bus.rd_data,            256'(0));
      release_reset();

      // Fill with a decrementing pattern, one past full.
      for (int i = 1; i <= 513; i++) begin
         step(1'b1, 32'hFFFF_FFFF - 32'(i - 1), 1'b0);
         if (i == 7)   chk("fill7_rd_empty", 256'(bus.rd_empty), 256'(1));
         if (i == 8)   chk("fill8_rd_empty", 256'(bus.rd_empty), 256'(0));
         if (i == 127) chk("fill127_almost_full", 256'(bus.almost_full), 256'(0));
         if (i == 128) begin
            chk("fill128_almost_full",  256'(bus.almost_full),  256'(1));
            chk("fill128_almost_empty", 256'(bus.almost_empty), 256'(0));
         end
         if (i == 511) chk("fill511_wr_full", 256'(bus.wr_full), 256'(0));
         if (i == 513) chk("fill513_wr_full", 256'(bus.wr_full), 256'(1));
      end
      chk("fill_model_count", 256'(q.size()), 256'(512));

      // Drain with one extra read past empty.
      for (int k = 0; k < 8; k++) lit[32*k +: 32] = 32'hFFFF_FFFF - 32'(k);
      for (int i = 0; i < 65; i++) begin
         step(1'b0, 32'h0, 1'b1);
`ifdef FIFO_OUTPUT_REG_EN
         if (i == 1) chk("drain_first_word", bus.rd_data, lit);
`else
         if (i == 0) chk("drain_first_word", bus.rd_data, lit);
`endif
      end
      for (int k = 0; k < 8; k++) lit[32*k +: 32] = 32'hFFFF_FFFF - 32'(504 + k);
      chk("drain_last_held", bus.rd_data, lit);
      chk("drain_rd_empty", 256'(bus.rd_empty), 256'(1));

      // Simultaneous write and read with 16 stored.
      for (int i = 0; i < 16; i++) step(1'b1, 32'h5000 + 32'(i), 1'b0);
      step(1'b1, 32'h5010, 1'b1);
      chk("simul_model_count", 256'(q.size()), 256'(9));
      chk("simul_rd_empty", 256'(bus.rd_empty), 256'(0));
      step(1'b0, 32'h0, 1'b1);
      repeat (2) step(1'b0, 32'h0, 1'b0);

      // Two wrap passes with random data, starting unaligned.
      fill_drain_random();
      fill_drain_random();

      // Random traffic in phases of different bias.
      for (int s = 0; s < 8; s++)
         for (int i = 0; i < 400; i++)
            step(32'($urandom_range(0, 99)) < wp[s % 4], $urandom,
                 32'($urandom_range(0, 99)) < rp[s % 4]);

      // Bring the level to exactly 300 words, then reset mid-operation.
      for (int i = 0; i < 80 && q.size() > 300; i++) step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 600 && q.size() < 300; i++) step(1'b1, $urandom, 1'b0);
      chk("midrst_model_count", 256'(q.size()), 256'(300));
      tb_rst = 1'b1;
      #1;
      chk("midrst_rd_empty",     256'(bus.rd_empty),     256'(1));
      chk("midrst_almost_full",  256'(bus.almost_full),  256'(0));
      chk("midrst_almost_empty", 256'(bus.almost_empty), 256'(1));
      chk("midrst_rd_data",      bus.rd_data,            256'(0));
      #40;
      release_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0);
      step(1'b0, 32'h0, 1'b1);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 8; k++) lit[32*k +: 32] = 32'h1000 + 32'(k);
      chk("midrst_readback", bus.rd_data, lit);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
